// File: rtl/regfile_param.sv
// Parametrised clocked register file: one write port, NUM_READ registered read ports,
// write-to-read bypass, pending-write scoreboard and a post-reset clear sequence.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         regWrite,
    input  logic [ADDR_W-1:0]            writeAddr,
    input  logic [DATA_W-1:0]            writeData,
    input  logic [NUM_READ*ADDR_W-1:0]   readAddr,
    output logic [NUM_READ*DATA_W-1:0]   readData,
    output logic [NUM_READ-1:0]          readBusy,
    input  logic                         issueValid,
    input  logic [ADDR_W-1:0]            issueAddr,
    output logic                         ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [ADDR_W-1:0]             cnt_r;
    logic [DATA_W-1:0]             mem_r [DEPTH];
    logic [DEPTH-1:0]              pending_r;
    logic [DEPTH-1:0]              pending_next_s;
    logic                          we_s;
    logic                          iv_s;
    logic [ADDR_W-1:0]             ra_s;
    logic [NUM_READ*DATA_W-1:0]    rdata_next_s;
    logic [NUM_READ-1:0]           busy_next_s;

    // Qualified write/issue strobes; a write to the hard-wired zero entry is dropped here.
    always_comb begin
        we_s = (state_r == RUN) && regWrite && !(ZERO_REG && (writeAddr == {ADDR_W{1'b0}}));
        iv_s = (state_r == RUN) && issueValid;
    end

    // Clear-sequence FSM next state: leave INIT once the last entry has been zeroed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: begin
                if (cnt_r == {ADDR_W{1'b1}}) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = INIT;
                end
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = INIT;
        endcase
    end

    // FSM state, clear counter and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= INIT;
            cnt_r   <= {ADDR_W{1'b0}};
            ready   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == INIT) begin
                cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            ready <= (state_next_s == RUN);
        end
    end

    // Storage array: cleared entry by entry during INIT, never reset directly.
    always_ff @(posedge clk) begin
        if (state_r == INIT) begin
            mem_r[cnt_r] <= {DATA_W{1'b0}};
        end else if (we_s) begin
            mem_r[writeAddr] <= writeData;
        end
    end

    // Pending scoreboard: clear on write, then set on issue so a newer producer wins.
    always_comb begin
        pending_next_s = pending_r;
        if (state_r == RUN) begin
            if (we_s) begin
                pending_next_s[writeAddr] = 1'b0;
            end else begin
                pending_next_s = pending_next_s;
            end
            if (iv_s) begin
                pending_next_s[issueAddr] = 1'b1;
            end else begin
                pending_next_s = pending_next_s;
            end
        end else begin
            pending_next_s = {DEPTH{1'b0}};
        end
        pending_next_s[0] = ZERO_REG ? 1'b0 : pending_next_s[0];
    end

    // Per-port read data and busy, including zero-register suppression and optional bypass.
    always_comb begin
        rdata_next_s = {(NUM_READ*DATA_W){1'b0}};
        busy_next_s  = {NUM_READ{1'b0}};
        ra_s         = {ADDR_W{1'b0}};
        for (int k = 0; k < NUM_READ; k++) begin
            ra_s = readAddr[k*ADDR_W +: ADDR_W];
            if (state_r != RUN) begin
                rdata_next_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if (ZERO_REG && (ra_s == {ADDR_W{1'b0}})) begin
                rdata_next_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if (BYPASS && we_s && (writeAddr == ra_s)) begin
                rdata_next_s[k*DATA_W +: DATA_W] = writeData;
            end else begin
                rdata_next_s[k*DATA_W +: DATA_W] = mem_r[ra_s];
            end
            busy_next_s[k] = pending_next_s[ra_s];
        end
    end

    // Registered outputs and scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readData  <= {(NUM_READ*DATA_W){1'b0}};
            readBusy  <= {NUM_READ{1'b0}};
            pending_r <= {DEPTH{1'b0}};
        end else begin
            readData  <= rdata_next_s;
            readBusy  <= busy_next_s;
            pending_r <= pending_next_s;
        end
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised, clocked successor to the combinational GPR file.
- Provides one synchronous write port and NUM_READ registered read ports.
- Includes write-to-read bypass, an optional hard-wired zero register, a pending-write scoreboard for multi-cycle producers, and a post-reset hardware clear sequence.
- Sits between decode (reads, issue marking) and write-back (writes) in the MIPS datapath.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_READ, 2, number of independent read ports.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes/issues; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = old value is returned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- regWrite  in  1  write enable, sampled at clk rise.
- writeAddr  in  ADDR_W  write destination.
- writeData  in  DATA_W  write value.
- readAddr  in  NUM_READ*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- readData  out  NUM_READ*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W].
- readBusy  out  NUM_READ  registered; 1 = addressed register has a write outstanding.
- issueValid  in  1  marks issueAddr as pending (load or multi-cycle op issued).
- issueAddr  in  ADDR_W  destination being marked pending.
- ready  out  1  1 = clear sequence done, block accepting operations.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - readData=0, readBusy=0, ready=0, all pending bits=0.
  - FSM goes to INIT and the clear counter goes to 0.
  - Array contents are not reset directly.
- FSM states: INIT, RUN.
  - INIT: each cycle writes 0 to entry[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, go to RUN; ready=1 from the next cycle.
  - INIT therefore lasts DEPTH cycles (32 by default).
  - In INIT, regWrite, issueValid and reads are ignored; readData and readBusy hold 0.
  - RUN persists until reset. A reset asserted mid-INIT or mid-RUN restarts INIT from cnt=0.
- Write (RUN): when regWrite=1 at the clk edge, entry[writeAddr] <= writeData.
  - If ZERO_REG=1 and writeAddr==0, the write is dropped.
- Read (RUN): 1-cycle latency. readData[k] <= entry[readAddr[k]] at each edge.
  - If ZERO_REG=1 and readAddr[k]==0, the result is 0.
  - If BYPASS=1, regWrite=1, writeAddr==readAddr[k] and the address is not the suppressed zero register, readData[k] <= writeData.
  - If BYPASS=0, the pre-write value is returned.
  - Ports are fully independent; duplicate addresses across ports are legal.
- Scoreboard (RUN): one pending bit per entry.
  - issueValid sets pending[issueAddr].
  - regWrite clears pending[writeAddr].
  - Same address, same cycle: set wins, so the bit stays 1 (newer producer).
  - Different addresses: both updates apply.
  - With ZERO_REG=1, pending[0] is constant 0.
  - Issue to an already-pending entry is legal and keeps it at 1.
- readBusy[k] <= pending_next[readAddr[k]], i.e. the pending value after this edge's set/clear, so a same-cycle clearing write reads not-busy, consistent with bypass.
- No output has a combinational path from inputs; all outputs are flops.

Test Plan:
- Reset released: ready=0 for 32 cycles then 1. Every address read afterwards returns 0 with readBusy=0, even after pre-reset writes of 0xFFFFFFFF.
- Write entry 9 = 0xDEADBEEF, read port 0 addr 9 on the next cycle: readData[0]=0xDEADBEEF one cycle after the address is applied.
- Same-cycle write 0x12345678 to entry 17 with both ports reading 17:
  - BYPASS=1: both ports return 0x12345678.
  - BYPASS=0: both ports return the old value.
- ZERO_REG=1: write 0xAAAA5555 to entry 0, then issue addr 0. Reading entry 0 gives 0, readBusy=0.
- Scoreboard on entry 8:
  - Issue 8, read 8: busy=1.
  - Write 8 = 0x5 while reading 8: data 0x5, busy=0.
  - Issue 8 and write 8 in the same cycle: busy=1.
- Pulse rst_n low during RUN after writes to entries 3 and 20: ready drops immediately and outputs go to 0. After 32 cycles ready=1, and entries 3 and 20 read 0.
